id_ex_skid: RTL and testbench
=============================

// Module: id_ex_skid
// PURPOSE
//  Elastic ID->EX pipeline register: a valid/ready handshake with a 2-entry skid buffer.
//  Carries operands, write-back control and ALU sel/op from decode to execute.
//  Adds stall back-pressure, flush and a saturating stall counter.
//  Sits between decode (id) and execute (ex). Full throughput, 1-cycle latency.
// PARAMETERS
//  DATA_W      32  operand width (id_data_a/b)
//  RADDR_W      5  register address width; NOP address is 0
//  SEL_W        3  ALU select width; NOP select is 0
//  OP_W         8  ALU op width; NOP op is 0
//  CNT_W       16  stall counter width
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        reset, asynchronous, active-high
//  flush_i          in   1        kill all held instructions
//  id_valid_i       in   1        decode presents an instruction
//  id_ready_o       out  1        stage can accept this cycle
//  id_data_a_i      in   DATA_W   operand A
//  id_data_b_i      in   DATA_W   operand B
//  id_we_i          in   1        register write enable
//  id_w_reg_addr_i  in   RADDR_W  destination register
//  id_sel_i         in   SEL_W    ALU result select
//  id_op_i          in   OP_W     ALU operation
//  ex_valid_o       out  1        execute-side instruction valid
//  ex_ready_i       in   1        execute consumes this cycle
//  ex_data_a_o      out  DATA_W   operand A
//  ex_data_b_o      out  DATA_W   operand B
//  ex_we_o          out  1        write enable, gated by ex_valid_o
//  ex_w_reg_addr_o  out  RADDR_W  destination register
//  ex_sel_o         out  SEL_W    ALU select
//  ex_op_o          out  OP_W     ALU op
//  stall_cnt_o      out  CNT_W    cycles with ex_valid_o=1 and ex_ready_i=0
// BEHAVIOUR
//  - Reset (async, rst=1): state EMPTY, id_ready_o=1, ex_valid_o=0, all ex_* payload=0,
//    stall_cnt_o=0. Skid buffer contents are don't-care.
//  - in  = id_valid_i & id_ready_o.  out = ex_valid_o & ex_ready_i.
//  - id_ready_o is a flop: 1 in EMPTY/BUSY, 0 in FULL. No combinational in->out path.
//  - Storage: main reg (drives ex_*) and skid reg.
//  - State transitions:
//    EMPTY: in -> BUSY, main<=input.
//    BUSY : in&!out -> FULL, skid<=input;  !in&out -> EMPTY;
//           in&out -> BUSY, main<=input;   neither -> hold.
//    FULL : out -> BUSY, main<=skid; else hold. id_valid_i is ignored.
//  - Latency: an instruction accepted at edge N is on ex_* after edge N (visible cycle N+1).
//    Order is strictly FIFO.
//  - Whenever ex_valid_o=0: ex_we_o=0, ex_w_reg_addr_o=0, ex_sel_o=0, ex_op_o=0,
//    ex_data_a/b_o=0.
//  - flush_i=1 at an edge: next state EMPTY, ex_valid_o=0, payload NOPs, id_ready_o=1.
//    Any simultaneous in/out is discarded. Flush has priority over every other event.
//  - stall_cnt_o: +1 each edge with ex_valid_o=1 & ex_ready_i=0 (flush edge included).
//    Saturates at all-ones. Cleared only by rst.
//  - Payload in main/skid never changes while held (stable under back-pressure).
// TESTING
//  1 Reset mid-stream: rst pulsed between edges -> outputs 0 and id_ready_o=1 immediately,
//    with no clock edge.
//  2 Streaming: ex_ready_i=1, 4 back-to-back ops A=1..4 ->
//    ex_data_a_o = 1,2,3,4 on consecutive cycles, id_ready_o stays 1.
//  3 Back-pressure: ex_ready_i=0, send A=0x11 then A=0x22 -> FULL, id_ready_o=0,
//    ex_data_a_o holds 0x11; on release, 0x11 then 0x22 emerge in order.
//  4 Flush when FULL with id_valid_i=1 -> next cycle ex_valid_o=0, ex_we_o=0,
//    id_ready_o=1; 0x22 is never emitted.
//  5 Stall counter (CNT_W=2): hold ex_ready_i=0 with a valid instruction for 5 cycles ->
//    stall_cnt_o = 1,2,3,3,3.
//  6 Invalid gating: id_valid_i=0, id_we_i=1, addr=5 -> ex_we_o=0,
//    ex_w_reg_addr_o=0 throughout.

Source files
------------

// File: rtl/id_ex_skid.sv
// id_ex_skid: elastic ID->EX pipeline register.
// A valid/ready stage with a main register (drives ex_*) and a skid register
// that catches one extra instruction when execute stalls. id_ready_o is a flop,
// so there is no combinational path from ex_ready_i back to decode.
// Also provides flush and a saturating stall-cycle counter.
module id_ex_skid #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int SEL_W   = 3,
  parameter int OP_W    = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               id_valid_i,
  output logic               id_ready_o,
  input  logic [DATA_W-1:0]  id_data_a_i,
  input  logic [DATA_W-1:0]  id_data_b_i,
  input  logic               id_we_i,
  input  logic [RADDR_W-1:0] id_w_reg_addr_i,
  input  logic [SEL_W-1:0]   id_sel_i,
  input  logic [OP_W-1:0]    id_op_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [DATA_W-1:0]  ex_data_a_o,
  output logic [DATA_W-1:0]  ex_data_b_o,
  output logic               ex_we_o,
  output logic [RADDR_W-1:0] ex_w_reg_addr_o,
  output logic [SEL_W-1:0]   ex_sel_o,
  output logic [OP_W-1:0]    ex_op_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0]  data_a;
    logic [DATA_W-1:0]  data_b;
    logic               we;
    logic [RADDR_W-1:0] w_reg_addr;
    logic [SEL_W-1:0]   sel;
    logic [OP_W-1:0]    op;
  } payload_t;

  // EMPTY: nothing held. BUSY: main valid. FULL: main and skid valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_id_ready;
  logic             r_ex_valid;
  payload_t         r_main;
  payload_t         r_skid;
  logic [CNT_W-1:0] r_stall_cnt;

  payload_t         w_in_payload;
  payload_t         w_ex_payload;
  logic             w_in;
  logic             w_out;
  logic             w_main_load_in;
  logic             w_main_load_skid;
  logic             w_skid_load;

  assign w_in  = id_valid_i & r_id_ready;
  assign w_out = r_ex_valid & ex_ready_i;

  assign w_in_payload = '{
    data_a:     id_data_a_i,
    data_b:     id_data_b_i,
    we:         id_we_i,
    w_reg_addr: id_w_reg_addr_i,
    sel:        id_sel_i,
    op:         id_op_i
  };

  // Next-state and register-load decode; flush overrides every handshake.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt      = r_state;
    w_main_load_in   = 1'b0;
    w_main_load_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            w_state_nxt    = ST_BUSY;
            w_main_load_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in && !w_out) begin
            w_state_nxt = ST_FULL;
            w_skid_load = 1'b1;
          end else if (!w_in && w_out) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_in && w_out) begin
            w_main_load_in = 1'b1;
          end
        end
        ST_FULL: begin
          // id_ready_o is low here, so w_in is always 0 and decode is ignored.
          if (w_out) begin
            w_state_nxt      = ST_BUSY;
            w_main_load_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and the main (output) register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_id_ready <= 1'b1;
      r_ex_valid <= 1'b0;
      r_main     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_state    <= w_state_nxt;
      r_id_ready <= (w_state_nxt != ST_FULL);
      r_ex_valid <= (w_state_nxt != ST_EMPTY);
      if (w_main_load_in) begin
        r_main <= w_in_payload;
      end else if (w_main_load_skid) begin
        r_main <= r_skid;
      end
    end
  end

  // Skid register captures the instruction that arrives while execute stalls.
  always_ff @(posedge clk) begin
    // NOTE: the skid data register is deliberately not reset; r_state says whether it is valid.
    if (w_skid_load) begin
      r_skid <= w_in_payload;
    end
  end

  // Count edges where execute holds off a valid instruction, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (r_ex_valid && !ex_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Present NOPs whenever the stage holds nothing valid.
  assign w_ex_payload = r_ex_valid ? r_main : '0;

  assign id_ready_o      = r_id_ready;
  assign ex_valid_o      = r_ex_valid;
  assign ex_data_a_o     = w_ex_payload.data_a;
  assign ex_data_b_o     = w_ex_payload.data_b;
  assign ex_we_o         = w_ex_payload.we;
  assign ex_w_reg_addr_o = w_ex_payload.w_reg_addr;
  assign ex_sel_o        = w_ex_payload.sel;
  assign ex_op_o         = w_ex_payload.op;
  assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: directed stimulus with a scoreboard queue and a separate
// output monitor for the id_ex_skid pipeline stage (CNT_W=2 so saturation is reachable).
module tb_id_ex_skid;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int SEL_W   = 3;
  localparam int OP_W    = 8;
  localparam int CNT_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic               we;
    logic [RADDR_W-1:0] addr;
    logic [SEL_W-1:0]   sel;
    logic [OP_W-1:0]    op;
  } pl_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush_i;
  logic               id_valid_i;
  logic               id_ready_o;
  logic [DATA_W-1:0]  id_data_a_i;
  logic [DATA_W-1:0]  id_data_b_i;
  logic               id_we_i;
  logic [RADDR_W-1:0] id_w_reg_addr_i;
  logic [SEL_W-1:0]   id_sel_i;
  logic [OP_W-1:0]    id_op_i;
  logic               ex_valid_o;
  logic               ex_ready_i;
  logic [DATA_W-1:0]  ex_data_a_o;
  logic [DATA_W-1:0]  ex_data_b_o;
  logic               ex_we_o;
  logic [RADDR_W-1:0] ex_w_reg_addr_o;
  logic [SEL_W-1:0]   ex_sel_o;
  logic [OP_W-1:0]    ex_op_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  int  n_checks = 0;
  int  n_errors = 0;
  pl_t exp_q[$];

  id_ex_skid #(
    .DATA_W(DATA_W), .RADDR_W(RADDR_W), .SEL_W(SEL_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .id_valid_i      (id_valid_i),
    .id_ready_o      (id_ready_o),
    .id_data_a_i     (id_data_a_i),
    .id_data_b_i     (id_data_b_i),
    .id_we_i         (id_we_i),
    .id_w_reg_addr_i (id_w_reg_addr_i),
    .id_sel_i        (id_sel_i),
    .id_op_i         (id_op_i),
    .ex_valid_o      (ex_valid_o),
    .ex_ready_i      (ex_ready_i),
    .ex_data_a_o     (ex_data_a_o),
    .ex_data_b_o     (ex_data_b_o),
    .ex_we_o         (ex_we_o),
    .ex_w_reg_addr_o (ex_w_reg_addr_o),
    .ex_sel_o        (ex_sel_o),
    .ex_op_o         (ex_op_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload derived from operand A so every field is distinct per vector.
  function automatic pl_t mk(input logic [DATA_W-1:0] a);
    pl_t p;
    p.a    = a;
    p.b    = ~a;
    p.we   = a[0];
    p.addr = a[RADDR_W-1:0];
    p.sel  = a[SEL_W-1:0];
    p.op   = a[OP_W-1:0];
    return p;
  endfunction

  task automatic drive(input logic v, input logic [DATA_W-1:0] a);
    pl_t p;
    p = mk(a);
    id_valid_i      = v;
    id_data_a_i     = p.a;
    id_data_b_i     = p.b;
    id_we_i         = p.we;
    id_w_reg_addr_i = p.addr;
    id_sel_i        = p.sel;
    id_op_i         = p.op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid&ready and no flush/reset.
  initial begin
    pl_t act;
    pl_t exp;
    forever begin
      @(negedge clk);
      act = '{a: ex_data_a_o, b: ex_data_b_o, we: ex_we_o, addr: ex_w_reg_addr_o,
              sel: ex_sel_o, op: ex_op_o};
      if (!ex_valid_o) begin
        check("nop_gating", act, '0);
      end else if (!rst && !flush_i && ex_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got a=%0h expected no output", act.a);
        end else begin
          exp = exp_q.pop_front();
          check("sb_payload", act, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    rst        = 1'b1;
    flush_i    = 1'b0;
    ex_ready_i = 1'b1;
    drive(1'b0, '0);
    #1;
    check("rst_valid", ex_valid_o, 0);
    check("rst_ready", id_ready_o, 1);
    check("rst_cnt",   stall_cnt_o, 0);
    check("rst_a",     ex_data_a_o, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();

    // Streaming: four back-to-back instructions, one per cycle.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(i));
      exp_q.push_back(mk(DATA_W'(i)));
      check("stream_ready", id_ready_o, 1);
      step();
      check("stream_a", ex_data_a_o, i);
    end
    drive(1'b0, '0);
    step();
    check("stream_drain_valid", ex_valid_o, 0);

    // Back-pressure: fill main and skid, decode is ignored while FULL.
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h11);
    exp_q.push_back(mk(32'h11));
    step();
    check("bp_a1", ex_data_a_o, 32'h11);
    check("bp_ready1", id_ready_o, 1);
    drive(1'b1, 32'h22);
    exp_q.push_back(mk(32'h22));
    step();
    check("bp_full_ready", id_ready_o, 0);
    check("bp_hold_a", ex_data_a_o, 32'h11);
    drive(1'b1, 32'h99);
    step();
    check("bp_ignore_ready", id_ready_o, 0);
    check("bp_ignore_a", ex_data_a_o, 32'h11);
    drive(1'b0, '0);
    ex_ready_i = 1'b1;
    step();
    check("bp_second_a", ex_data_a_o, 32'h22);
    check("bp_release_ready", id_ready_o, 1);
    step();
    check("bp_drain_valid", ex_valid_o, 0);

    // Flush while FULL with a new instruction and execute ready on the same edge.
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h11);
    exp_q.push_back(mk(32'h11));
    step();
    drive(1'b1, 32'h22);
    exp_q.push_back(mk(32'h22));
    step();
    check("fl_full_ready", id_ready_o, 0);
    drive(1'b1, 32'h55);
    flush_i    = 1'b1;
    ex_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    exp_q.delete();
    drive(1'b0, '0);
    check("fl_valid", ex_valid_o, 0);
    check("fl_we",    ex_we_o, 0);
    check("fl_ready", id_ready_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_quiet_valid", ex_valid_o, 0);
    end

    // Asynchronous reset between edges while FULL.
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h66);
    exp_q.push_back(mk(32'h66));
    step();
    drive(1'b1, 32'h77);
    exp_q.push_back(mk(32'h77));
    step();
    check("ar_full_ready", id_ready_o, 0);
    drive(1'b0, '0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", ex_valid_o, 0);
    check("ar_ready", id_ready_o, 1);
    check("ar_a",     ex_data_a_o, 0);
    check("ar_we",    ex_we_o, 0);
    check("ar_cnt",   stall_cnt_o, 0);
    exp_q.delete();
    #3 rst = 1'b0;
    step();
    check("ar_after_valid", ex_valid_o, 0);
    check("ar_after_ready", id_ready_o, 1);

    // Stall counter saturation with CNT_W=2.
    drive(1'b1, 32'hA5);
    exp_q.push_back(mk(32'hA5));
    step();
    check("sc_start", stall_cnt_o, 0);
    drive(1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("sc_count", stall_cnt_o, exp_cnt[i]);
    end
    ex_ready_i = 1'b1;
    step();
    step();
    check("sc_drain_valid", ex_valid_o, 0);
    check("sc_held", stall_cnt_o, 3);

    // Invalid gating: write-enable and address on the input never leak out.
    id_valid_i      = 1'b0;
    id_we_i         = 1'b1;
    id_w_reg_addr_i = 5'd5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_we",   ex_we_o, 0);
      check("gate_addr", ex_w_reg_addr_o, 0);
    end

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
